// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request and response channels around a word RAM,
// with RV32I byte/half/word sizing, load extension, error flagging and fixed access latency.
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        f3_q;

    logic [31:0]       mem [2**ADDR_W];

    logic              accept;
    logic              fire;
    logic              f3_ok;
    logic              misalign;
    logic              out_of_range;
    logic              acc_err;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_data;
    logic [3:0]        byte_en;
    logic [31:0]       wr_word;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;
    assign fire      = (state == WAIT) && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are captured only at accept; the access works from these copies.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                f3_q    <= req_funct3;
                cnt     <= CNT_INIT;
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (fire) begin
                rsp_rdata <= load_data;
                rsp_err   <= acc_err;
            end
        end
    end

    always_comb begin
        if (we_q) begin
            f3_ok = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010);
        end else begin
            f3_ok = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010) ||
                    (f3_q == 3'b100) || (f3_q == 3'b101);
        end
    end

    assign misalign     = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                          ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    assign out_of_range = |addr_q[31:ADDR_W+2];
    assign acc_err      = !f3_ok || misalign || out_of_range;

    assign word_idx = addr_q[ADDR_W+1:2];
    assign lane     = addr_q[1:0];
    assign rd_word  = mem[word_idx];
    assign rd_byte  = rd_word[{lane, 3'b000} +: 8];
    assign rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = '0;
        if (!acc_err && !we_q) begin
            case (f3_q)
                3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
                3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
                3'b010:  load_data = rd_word;
                3'b100:  load_data = {24'd0, rd_byte};
                3'b101:  load_data = {16'd0, rd_half};
                default: load_data = '0;
            endcase
        end
    end

    always_comb begin
        byte_en = 4'b0000;
        case (f3_q[1:0])
            2'b00:   byte_en = 4'b0001 << lane;
            2'b01:   byte_en = 4'b0011 << lane;
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    assign wr_word = wdata_q << {lane, 3'b000};

    // Gated by rst so a store still in WAIT when reset arrives never reaches the RAM.
    always_ff @(posedge clk) begin
        if (!rst && fire && we_q && !acc_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
            end
        end
    end

endmodule
